// File: rtl/uart_rx_core.sv
// uart_rx_core
// Oversampling UART receiver with a configurable frame format. The rxd line is
// synchronised, the start bit is validated at its centre, and data bits are
// taken LSB first at mid-bit. The optional parity bit and 1 or 2 stop bits are
// checked. Each completed word is offered on a valid/ready stream together
// with its parity and framing flags. A word that completes while the output
// register is still occupied is dropped and flagged with a one-cycle overrun
// pulse.
module uart_rx_core #(
  parameter int CLK_HZ      = 12000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  // Number of clk cycles per oversample tick (floor division).
  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BI_W  = $clog2(DATA_BITS);

  // Sub-counter compare points: centre of the start bit, and one full bit
  // period after a previous centre sample.
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
  localparam logic            SB_LAST = 1'(STOP_BITS - 1);

  // XOR over data and parity bit that a correct frame must produce:
  // odd parity needs an odd count of ones, even parity an even count.
  localparam logic PAR_TARGET = (PARITY == 1);

  // Parameter sanity checks, evaluated at elaboration.
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_core: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_core: OVERSAMPLE must be even and at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_core: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;

  assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

  // Free-running divider, wraps to zero on the tick cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // rxd synchroniser: the line idles high, so the chain resets to ones and a
  // reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // Shift the raw line through the synchroniser flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rxd};
    end
  end

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_t                state_reg, state_next;
  logic [SC_W-1:0]       sc_reg, sc_next;
  logic [BI_W-1:0]       bit_idx_reg, bit_idx_next;
  logic                  stop_idx_reg, stop_idx_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic                  pe_reg, pe_next;
  logic                  fe_reg, fe_next;
  logic                  rearm_reg, rearm_next;
  logic                  commit;

  // State register and per-frame working registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      sc_reg       <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      pe_reg       <= 1'b0;
      fe_reg       <= 1'b0;
      rearm_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      sc_reg       <= sc_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      shift_reg    <= shift_next;
      pe_reg       <= pe_next;
      fe_reg       <= fe_next;
      rearm_reg    <= rearm_next;
    end
  end

  // Next-state logic; the machine only advances on oversample ticks.
  always_comb begin
    state_next    = state_reg;
    sc_next       = sc_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    shift_next    = shift_reg;
    pe_next       = pe_reg;
    fe_next       = fe_reg;
    rearm_next    = rearm_reg;
    commit        = 1'b0;

    if (tick) begin
      case (state_reg)
        S_IDLE: begin
          if (rearm_reg) begin
            if (!rx_s) begin
              state_next = S_START;
              sc_next    = '0;
            end
          end else if (rx_s) begin
            // Line has recovered from a break; allow the next start bit.
            rearm_next = 1'b1;
          end
        end

        S_START: begin
          if (sc_reg == SC_HALF) begin
            if (rx_s) begin
              // Low pulse shorter than half a bit: treat as noise.
              state_next = S_IDLE;
            end else begin
              state_next   = S_DATA;
              sc_next      = '0;
              bit_idx_next = '0;
              pe_next      = 1'b0;
              fe_next      = 1'b0;
            end
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end

        S_DATA: begin
          if (sc_reg == SC_LAST) begin
            sc_next                = '0;
            shift_next[bit_idx_reg] = rx_s;
            if (bit_idx_reg == BI_LAST) begin
              bit_idx_next  = '0;
              stop_idx_next = 1'b0;
              state_next    = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 1'b1;
            end
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end

        S_PARITY: begin
          if (sc_reg == SC_LAST) begin
            sc_next       = '0;
            pe_next       = ((^shift_reg) ^ rx_s) != PAR_TARGET;
            stop_idx_next = 1'b0;
            state_next    = S_STOP;
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end

        S_STOP: begin
          if (sc_reg == SC_LAST) begin
            sc_next = '0;
            fe_next = fe_reg | ~rx_s;
            if (stop_idx_reg == SB_LAST) begin
              // Word is complete at the centre of the last stop bit; going
              // idle here leaves half a bit of margin before the next start.
              commit     = 1'b1;
              state_next = S_IDLE;
              if (fe_next) begin
                // A low stop bit may be a break: wait for the line to go
                // high before accepting another start bit.
                rearm_next = 1'b0;
              end
            end else begin
              stop_idx_next = stop_idx_reg + 1'b1;
            end
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output word register and valid/ready handshake
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] m_data_reg;
  logic                 m_valid_reg;
  logic                 parity_err_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;

  // Load a committed word when the register is free or being emptied this
  // cycle; otherwise keep the pending word and flag the loss.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_data_reg     <= '0;
      m_valid_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (commit) begin
        if (!m_valid_reg || m_ready) begin
          m_data_reg     <= shift_reg;
          parity_err_reg <= pe_reg;
          frame_err_reg  <= fe_next;
          m_valid_reg    <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  // Output decode: busy follows the state directly, the stream comes from
  // the output register.
  always_comb begin
    busy       = (state_reg != S_IDLE);
    m_data     = m_data_reg;
    m_valid    = m_valid_reg;
    parity_err = parity_err_reg;
    frame_err  = frame_err_reg;
    overrun    = overrun_reg;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receiver, successor to the board-level fixed 8-bit receive logic. Oversamples a synchronised rxd line, validates the start bit, and shifts in a configurable number of data bits LSB first. Supports optional odd/even parity and 1 or 2 stop bits. Delivers each word over a valid/ready stream interface with per-word error flags, and reports overrun. Sits between the FTDI pin and downstream consumers (LED display, command decoder, FIFO).

Parameters:
CLK_HZ, 12000000, fabric clock frequency in Hz
BAUD, 9600, line rate in bits/s
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, stop bits per frame (1 or 2)
OVERSAMPLE, 16, sample ticks per bit (even, >=4)
SYNC_STAGES, 3, rxd synchroniser depth (>=2)

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
rxd  input  1  asynchronous serial input, idle high
m_data  output  DATA_BITS  received word
m_valid  output  1  m_data and flags valid
m_ready  input  1  consumer accepts word when m_valid&&m_ready
parity_err  output  1  parity mismatch for current m_data (0 when PARITY=0)
frame_err  output  1  any stop bit sampled low for current m_data
overrun  output  1  one-cycle pulse: completed word dropped
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (resetn low at a clk edge): all sync stages=1, tick/bit counters=0, state=IDLE, m_data=0, m_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, rearm flag=1. Reset mid-frame abandons the frame; no partial word is ever delivered.
- Tick: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer floor; elaboration error if DIV<1. The divider counts 0..DIV-1 and pulses tick at DIV-1; it free-runs from reset.
- rxd passes through SYNC_STAGES flops; all sampling uses the last stage (rx_s).
- State machine, evaluated on tick only; sub-counter sc counts ticks within a bit:
  - IDLE: if rearm=1 and rx_s=0, go to START with sc=0. If rearm=0, set rearm=1 on rx_s=1.
  - START: at sc=OVERSAMPLE/2-1, if rx_s=1 (glitch) return to IDLE; else go to DATA with sc=0, bit index=0.
  - DATA: at sc=OVERSAMPLE-1 (mid-bit), shift rx_s into bit[index] (LSB first) and set sc=0. After bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample at mid-bit. Error if XOR(data,sample) != (PARITY==1 ? 1 : 0), i.e. odd parity requires an odd count of ones over data+parity, even requires an even count.
  - STOP: sample each stop bit at mid-bit; frame_err_next |= ~rx_s. After the last stop-bit sample, commit the word and go to IDLE immediately (mid-stop). If frame_err_next=1, clear rearm so a break or stuck-low line yields exactly one word.
- Commit, on the clk after the last stop-bit sample:
  - Register free (m_valid=0, or m_valid&&m_ready this cycle): load m_data/parity_err/frame_err and set m_valid=1.
  - Register full with m_ready=0: keep the old word and flags, drop the new word, pulse overrun for 1 cycle.
- Handshake: m_valid, m_data and the flags are stable while m_valid&&!m_ready. An accept with no commit clears m_valid next cycle. An accept coincident with a commit keeps m_valid=1 and presents the new word.
- Latency: m_valid rises 1 clk after the tick of the final stop-bit sample.
- busy is combinational from state (state!=IDLE).

Test Plan:
All scenarios use CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV=1, one bit = 16 clks), m_ready=1 unless stated.
- 8N1, send 0xA5 -> one m_valid cycle, m_data=0xA5, parity_err=0, frame_err=0, overrun=0; m_valid rises 1 clk after the stop-bit mid-sample.
- rxd low for 4 clks then high -> START rejects the glitch; no m_valid, busy returns 0 within 9 clks.
- PARITY=2, send 0x03 with parity bit=1 -> m_data=0x03, parity_err=1. Repeat with parity bit=0 -> parity_err=0. PARITY=1 with 0x01 and parity bit=0 -> parity_err=0.
- 8N1, send 0x00 then hold rxd low for 30 bit times -> exactly one word, m_data=0x00, frame_err=1. A valid 0x5A after rxd returns high -> m_data=0x5A, frame_err=0.
- m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11, one overrun pulse at the second commit. Then m_ready=1 -> 0x11 is accepted and m_valid drops; 0x22 is never seen.
- Assert resetn=0 for 1 clk mid-DATA of 0xFF -> all outputs reset, no word delivered. The next frame 0x3C is received correctly. With DATA_BITS=7, STOP_BITS=2, send 0x7F -> m_data=0x7F, flags 0.
